// File: rtl/sobel_stream_engine_if.sv
// sobel_stream_engine_if
// Groups the pixel-in handshake and the edge-out stream of the Sobel engine.
//   pix_data / pix_valid / pix_ready : raster-order pixel input, valid/ready
//   valid / edge_out                 : one edge magnitude per input pixel
//   busy / frame_done                : frame status and last-output pulse
// Modports:
//   master : pixel source + edge-map sink side
//   slave  : engine side
interface sobel_stream_engine_if #(
    parameter int PIX_W = 8
) ();
    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;
    logic             valid;
    logic [PIX_W-1:0] edge_out;
    logic             busy;
    logic             frame_done;

    modport master (
        output pix_data, pix_valid,
        input  pix_ready, valid, edge_out, busy, frame_done
    );

    modport slave (
        input  pix_data, pix_valid,
        output pix_ready, valid, edge_out, busy, frame_done
    );
endinterface

// File: rtl/sobel_stream_engine.sv
// sobel_stream_engine
// Streaming 3x3 Sobel edge detector with two line buffers and a 3x3 window.
// One edge magnitude is emitted per input pixel, in raster order. The output
// for centre index k appears one cycle after the accept of index k+IMG_W+1;
// the last IMG_W+1 outputs are produced by a FLUSH phase with no input.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   s_if : sobel_stream_engine_if.slave (pixel handshake, edge stream, status)
// Optional feature: define SOBEL_THRESH_EN to binarise the clamped magnitude
// against THRESH (border pixels stay 0).
module sobel_stream_engine #(
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 32,
    parameter int PIX_W    = 8,
    parameter int MAG_MODE = 0,
    parameter int THRESH   = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    sobel_stream_engine_if.slave  s_if
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int FW = $clog2(IMG_W + 1);
    localparam int GW = PIX_W + 4;   // Gx/Gy width
    localparam int SW = PIX_W + 5;   // Gx+Gy and |Gx|+|Gy| width
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [FW-1:0] F_LAST = FW'(IMG_W);

    if (IMG_W < 4 || IMG_H < 4 || THRESH < 0) begin : g_bad_param
        $error("sobel_stream_engine: IMG_W/IMG_H must be >= 4 and THRESH >= 0");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_t;

    state_t           r_state;
    logic [XW-1:0]    r_x_in, r_x_out;
    logic [YW-1:0]    r_y_in, r_y_out;
    logic [FW-1:0]    r_flush_cnt;
    logic             r_pix_ready, r_valid, r_busy, r_frame_done;
    logic [PIX_W-1:0] r_edge;
    logic [PIX_W-1:0] r_lb_top [IMG_W];   // row y-2 relative to the input row
    logic [PIX_W-1:0] r_lb_mid [IMG_W];   // row y-1 relative to the input row
    logic [PIX_W-1:0] r_win_l  [3];       // window column x-1 (top, mid, bottom)
    logic [PIX_W-1:0] r_win_m  [3];       // window column x

    logic             w_accept, w_flush_step, w_step, w_emit;
    logic             w_border, w_last_out, w_last_in;
    logic [PIX_W-1:0] w_col [3];
    logic signed [GW-1:0] w_l [3], w_m [3], w_r [3];
    logic signed [GW-1:0] w_gx, w_gy;
    logic signed [SW-1:0] w_gx_e, w_gy_e, w_abs_x, w_abs_y, w_sum, w_sum_adj, w_mag;
    logic [PIX_W-1:0] w_clamped, w_value, w_edge_next;

    assign w_accept     = s_if.pix_valid & r_pix_ready;
    assign w_flush_step = (r_state == S_FLUSH);
    assign w_step       = w_accept | w_flush_step;
    assign w_last_in    = (r_x_in == X_LAST) && (r_y_in == Y_LAST);
    // An output exists once input index IMG_W+1 is reached; every flush step emits.
    assign w_emit       = (w_accept && ((r_y_in > YW'(1)) || (r_y_in == YW'(1) && r_x_in != '0)))
                        || w_flush_step;
    assign w_border     = (r_x_out == '0) || (r_x_out == X_LAST) ||
                          (r_y_out == '0) || (r_y_out == Y_LAST);
    assign w_last_out   = (r_x_out == X_LAST) && (r_y_out == Y_LAST);

    // Right-hand window column comes straight from the line buffers and the
    // incoming pixel. Flush outputs are all border, so a zero column is fine.
    assign w_col[0] = w_accept ? r_lb_top[r_x_in] : '0;
    assign w_col[1] = w_accept ? r_lb_mid[r_x_in] : '0;
    assign w_col[2] = w_accept ? s_if.pix_data    : '0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_win_ext
        assign w_l[gi] = {4'b0000, r_win_l[gi]};
        assign w_m[gi] = {4'b0000, r_win_m[gi]};
        assign w_r[gi] = {4'b0000, w_col[gi]};
    end

    assign w_gx = w_l[0] + (w_l[1] <<< 1) + w_l[2] - w_r[0] - (w_r[1] <<< 1) - w_r[2];
    assign w_gy = w_l[0] + (w_m[0] <<< 1) + w_r[0] - w_l[2] - (w_m[2] <<< 1) - w_r[2];

    always_comb begin
        w_gx_e    = {w_gx[GW-1], w_gx};
        w_gy_e    = {w_gy[GW-1], w_gy};
        w_abs_x   = w_gx_e[SW-1] ? -w_gx_e : w_gx_e;
        w_abs_y   = w_gy_e[SW-1] ? -w_gy_e : w_gy_e;
        w_sum     = w_gx_e + w_gy_e;
        // Adding the sign bit before the arithmetic shift rounds toward zero.
        w_sum_adj = w_sum + {{(SW-1){1'b0}}, w_sum[SW-1]};
        if (MAG_MODE == 0) begin
            w_mag = w_sum_adj >>> 1;
        end else begin
            w_mag = w_abs_x + w_abs_y;
        end
        if (w_mag[SW-1]) begin
            w_clamped = '0;
        end else if (|w_mag[SW-2:PIX_W]) begin
            w_clamped = '1;
        end else begin
            w_clamped = w_mag[PIX_W-1:0];
        end
`ifdef SOBEL_THRESH_EN
        w_value = (int'(w_clamped) >= THRESH) ? '1 : '0;
`else
        w_value = w_clamped;
`endif
        w_edge_next = w_border ? '0 : w_value;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_x_in       <= '0;
            r_y_in       <= '0;
            r_x_out      <= '0;
            r_y_out      <= '0;
            r_flush_cnt  <= '0;
            r_pix_ready  <= 1'b0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_edge       <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                r_lb_top[i] <= '0;
                r_lb_mid[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                r_win_l[i] <= '0;
                r_win_m[i] <= '0;
            end
        end else begin
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;

            if (w_emit) begin
                r_valid      <= 1'b1;
                r_edge       <= w_edge_next;
                r_frame_done <= w_last_out;
                if (r_x_out == X_LAST) begin
                    r_x_out <= '0;
                    r_y_out <= (r_y_out == Y_LAST) ? '0 : r_y_out + 1'b1;
                end else begin
                    r_x_out <= r_x_out + 1'b1;
                end
            end

            if (w_step) begin
                for (int i = 0; i < 3; i++) begin
                    r_win_l[i] <= r_win_m[i];
                    r_win_m[i] <= w_col[i];
                end
            end

            if (w_accept) begin
                r_lb_top[r_x_in] <= r_lb_mid[r_x_in];
                r_lb_mid[r_x_in] <= s_if.pix_data;
                if (r_x_in == X_LAST) begin
                    r_x_in <= '0;
                    r_y_in <= (r_y_in == Y_LAST) ? '0 : r_y_in + 1'b1;
                end else begin
                    r_x_in <= r_x_in + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    r_pix_ready <= 1'b1;
                    if (w_accept) begin
                        r_state <= S_ACTIVE;
                        r_busy  <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (w_accept && w_last_in) begin
                        r_state     <= S_FLUSH;
                        r_pix_ready <= 1'b0;
                        r_flush_cnt <= '0;
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt == F_LAST) begin
                        r_state     <= S_IDLE;
                        r_pix_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_if.pix_ready  = r_pix_ready;
    assign s_if.valid      = r_valid;
    assign s_if.edge_out   = r_edge;
    assign s_if.busy       = r_busy;
    assign s_if.frame_done = r_frame_done;
endmodule

// File: tb/tb_sobel_stream_engine.sv
// tb_sobel_stream_engine
// Drives two engines (MAG_MODE 0 and 1, 8x8 frames) with the same pixel
// stream. Frame-level vectors give hand-computed interior output rows for
// column/row-constant images; random images are checked against a direct
// evaluation of the Sobel kernels. Also covers stalls, flush handshake,
// frame_done position and a mid-frame reset.
module tb_sobel_stream_engine;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int N  = W * H;
    localparam int PW = 8;
    localparam int TH = 128;
    localparam int NV = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PW-1:0] pix_data = '0;
    logic          pix_valid = 1'b0;

    always #5 clk = ~clk;

    sobel_stream_engine_if #(.PIX_W(PW)) if0 ();
    sobel_stream_engine_if #(.PIX_W(PW)) if1 ();

    assign if0.pix_data  = pix_data;
    assign if0.pix_valid = pix_valid;
    assign if1.pix_data  = pix_data;
    assign if1.pix_valid = pix_valid;

    sobel_stream_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .MAG_MODE(0), .THRESH(TH)) u_dut0 (
        .clk (clk), .rst (rst), .s_if (if0)
    );
    sobel_stream_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .MAG_MODE(1), .THRESH(TH)) u_dut1 (
        .clk (clk), .rst (rst), .s_if (if1)
    );

    typedef struct {
        int pat;      // image pattern code
        bit gaps;     // random pix_valid gaps
        int r0 [W];   // interior-row outputs, MAG_MODE 0 (clamped magnitude)
        int r1 [W];   // interior-row outputs, MAG_MODE 1
    } vec_t;

    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   img  [N];
    int   exp0 [N];
    int   exp1 [N];
    int   q0 [$];
    int   q1 [$];
    int   fd_cnt0, fd_cnt1, fd_idx0, fd_idx1, nrdy_cnt, stall_viol;
    bit   acc_pend = 1'b0;
    bit   rdy_pend = 1'b0;

    // Output monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (if0.valid) begin
            q0.push_back(int'(if0.edge_out));
            if (rdy_pend && !acc_pend) stall_viol++;
        end
        if (if1.valid) begin
            q1.push_back(int'(if1.edge_out));
            if (rdy_pend && !acc_pend) stall_viol++;
        end
        if (if0.frame_done) begin fd_cnt0++; fd_idx0 = q0.size() - 1; end
        if (if1.frame_done) begin fd_cnt1++; fd_idx1 = q1.size() - 1; end
        if (rst && !if0.pix_ready) nrdy_cnt++;
        acc_pend = pix_valid && if0.pix_ready;
        rdy_pend = if0.pix_ready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int pix_of(input int pat, input int x, input int y);
        case (pat)
            0:       return 100;
            1:       return (x < 4) ? 255 : 0;
            2:       return (x < 4) ? 0 : 255;
            3:       return 20 * x;
            4:       return 140 - 20 * x;
            5:       return 20 * y;
            6:       return 140 - 20 * y;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic int thr(input int v);
`ifdef SOBEL_THRESH_EN
        return (v >= TH) ? 255 : 0;
`else
        return v;
`endif
    endfunction

    function automatic int p(input int x, input int y);
        return img[y * W + x];
    endfunction

    function automatic int golden(input int mode, input int x, input int y);
        int gx, gy, m;
        if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 0;
        gx = p(x-1, y-1) + 2 * p(x-1, y) + p(x-1, y+1) - p(x+1, y-1) - 2 * p(x+1, y) - p(x+1, y+1);
        gy = p(x-1, y-1) + 2 * p(x, y-1) + p(x+1, y-1) - p(x-1, y+1) - 2 * p(x, y+1) - p(x+1, y+1);
        if (mode == 0) m = (gx + gy) / 2;
        else           m = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
        if (m < 0)   m = 0;
        if (m > 255) m = 255;
        return thr(m);
    endfunction

    task automatic set_vec(input int idx, input int pat, input bit gaps,
                           input int a [W], input int b [W]);
        vecs[idx].pat  = pat;
        vecs[idx].gaps = gaps;
        vecs[idx].r0   = a;
        vecs[idx].r1   = b;
    endtask

    task automatic start_frame();
        q0.delete();
        q1.delete();
        fd_cnt0 = 0; fd_cnt1 = 0; fd_idx0 = -1; fd_idx1 = -1;
        nrdy_cnt = 0; stall_viol = 0;
    endtask

    // Sends pixels 0..stop_at-1; for a full frame also holds pix_valid high
    // with junk data through FLUSH, dropping it as soon as pix_ready returns.
    task automatic drive_frame(input bit gaps, input int stop_at);
        int g, t;
        for (int i = 0; i < N; i++) begin
            if (i == stop_at) return;
            if (gaps) begin
                g = 0;
                while (g < 4 && $urandom_range(0, 1) == 1) begin
                    pix_valid = 1'b0;
                    pix_data  = PW'($urandom_range(0, 255));
                    @(posedge clk); #1;
                    g++;
                end
            end
            pix_data  = PW'(img[i]);
            pix_valid = 1'b1;
            t = 0;
            while (!if0.pix_ready && t < 20) begin @(posedge clk); #1; t++; end
            if (t == 20) chk("ready_timeout", int'(if0.pix_ready), 1);
            @(posedge clk); #1;
            if (i == 1) chk("busy_mid_frame", int'(if0.busy), 1);
        end
        pix_data  = 8'hAA;
        pix_valid = 1'b1;
        t = 0;
        while (!if0.pix_ready && t < 50) begin @(posedge clk); #1; t++; end
        pix_valid = 1'b0;
        chk("flush_end_ready", int'(if0.pix_ready), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string name);
        chk({name, " count_m0"}, q0.size(), N);
        chk({name, " count_m1"}, q1.size(), N);
        for (int k = 0; k < N && k < q0.size(); k++)
            chk($sformatf("%s m0 out%0d", name, k), q0[k], exp0[k]);
        for (int k = 0; k < N && k < q1.size(); k++)
            chk($sformatf("%s m1 out%0d", name, k), q1[k], exp1[k]);
        chk({name, " frame_done_count_m0"}, fd_cnt0, 1);
        chk({name, " frame_done_index_m0"}, fd_idx0, N - 1);
        chk({name, " frame_done_count_m1"}, fd_cnt1, 1);
        chk({name, " frame_done_index_m1"}, fd_idx1, N - 1);
        chk({name, " flush_not_ready_cycles"}, nrdy_cnt, W + 1);
        chk({name, " valid_during_stall"}, stall_viol, 0);
        chk({name, " busy_after_m0"}, int'(if0.busy), 0);
        chk({name, " busy_after_m1"}, int'(if1.busy), 0);
        $display("frame %s: %0d/%0d outputs, errors so far %0d", name, q0.size(), q1.size(), n_fail);
    endtask

    task automatic build_golden(input int pat);
        for (int k = 0; k < N; k++) img[k] = pix_of(pat, k % W, k / W);
        for (int k = 0; k < N; k++) begin
            exp0[k] = golden(0, k % W, k / W);
            exp1[k] = golden(1, k % W, k / W);
        end
    endtask

    initial begin
        int z   [W] = '{0, 0, 0, 0, 0, 0, 0, 0};
        int st  [W] = '{0, 0, 0, 255, 255, 0, 0, 0};
        int r160[W] = '{0, 160, 160, 160, 160, 160, 160, 0};
        int r80 [W] = '{0, 80, 80, 80, 80, 80, 80, 0};
        int x, y;

        set_vec(0, 0, 1'b0, z,    z);     // flat 100
        set_vec(1, 1, 1'b0, st,   st);    // step 255|0: Gx=+1020
        set_vec(2, 2, 1'b0, z,    st);    // step 0|255: Gx=-1020
        set_vec(3, 3, 1'b0, z,    r160);  // column ramp up: Gx=-160
        set_vec(4, 4, 1'b0, r80,  r160);  // column ramp down: Gx=+160
        set_vec(5, 5, 1'b0, z,    r160);  // row ramp up: Gy=-160
        set_vec(6, 6, 1'b0, r80,  r160);  // row ramp down: Gy=+160
        set_vec(7, 1, 1'b1, st,   st);    // step with stalls
        set_vec(8, 0, 1'b1, z,    z);     // flat with stalls

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", int'(if0.valid), 0);
        chk("reset edge_out", int'(if0.edge_out), 0);
        chk("reset busy", int'(if0.busy), 0);
        chk("reset frame_done", int'(if0.frame_done), 0);
        chk("reset pix_ready", int'(if0.pix_ready), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle pix_ready", int'(if0.pix_ready), 1);
        chk("idle busy", int'(if0.busy), 0);

        for (int v = 0; v < NV; v++) begin
            for (int k = 0; k < N; k++) begin
                x = k % W;
                y = k / W;
                img[k] = pix_of(vecs[v].pat, x, y);
                if (y == 0 || y == H - 1) begin
                    exp0[k] = 0;
                    exp1[k] = 0;
                end else begin
                    exp0[k] = thr(vecs[v].r0[x]);
                    exp1[k] = thr(vecs[v].r1[x]);
                end
            end
            start_frame();
            drive_frame(vecs[v].gaps, N);
            check_frame($sformatf("vec%0d", v));
        end

        // Random image with stalls against the kernel model
        build_golden(99);
        start_frame();
        drive_frame(1'b1, N);
        check_frame("random_gaps");

        // Mid-frame reset at pixel 30
        build_golden(99);
        start_frame();
        drive_frame(1'b0, 30);
        pix_data = PW'(img[30]);
        #2 rst = 1'b0;
        #1;
        chk("midreset valid", int'(if0.valid), 0);
        chk("midreset edge_out", int'(if0.edge_out), 0);
        chk("midreset edge_out_m1", int'(if1.edge_out), 0);
        chk("midreset busy", int'(if0.busy), 0);
        chk("midreset pix_ready", int'(if0.pix_ready), 0);
        chk("midreset frame_done", int'(if0.frame_done), 0);
        pix_valid = 1'b0;
        q0.delete();
        q1.delete();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no outputs after reset m0", q0.size(), 0);
        chk("no outputs after reset m1", q1.size(), 0);
        $display("frame midreset: reset applied after 30 pixels, errors so far %0d", n_fail);

        build_golden(98);
        start_frame();
        drive_frame(1'b0, N);
        check_frame("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sobel_stream_engine.md
Name: sobel_stream_engine

Overview:
- Parametrised streaming Sobel edge detector; successor to the fixed 32x32, 8-bit frame-buffered engine.
- Takes a raster-order pixel stream with a valid/ready handshake.
- Holds only two line buffers plus a 3x3 window, not a full frame store.
- Emits one edge magnitude per input pixel, in raster order. Sits between the pixel source and the edge-map sink.

Parameters:
- IMG_W, 32, image width in pixels (>=4)
- IMG_H, 32, image height in lines (>=4)
- PIX_W, 8, pixel and edge_out bit width
- MAG_MODE, 0, 0 = (Gx+Gy)/2 legacy magnitude; 1 = |Gx|+|Gy|
- THRESH, 128, binarisation threshold (used only with SOBEL_THRESH_EN)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- pix_data  in  PIX_W  input pixel
- pix_valid  in  1  pix_data is valid
- pix_ready  out  1  engine accepts a pixel this cycle
- valid  out  1  edge_out is valid (one-cycle qualifier, no backpressure)
- edge_out  out  PIX_W  edge magnitude
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse with the last output of a frame

Behaviour:
- Reset (rst=0, async) clears all state: state=IDLE, valid=0, edge_out=0, busy=0, frame_done=0, pix_ready=0 while in reset; counters and line buffers cleared. Reset mid-frame abandons the frame; no partial outputs follow.
- Accept = pix_valid & pix_ready.
- Pixel index n = y*IMG_W + x, in raster order; the first accept after IDLE is (0,0).
- States:
  - IDLE: pix_ready=1, busy=0. First accept → ACTIVE, busy=1 the next cycle.
  - ACTIVE: pix_ready=1. Input counters x,y advance per accept and wrap x at IMG_W-1. The accept of index IMG_W*IMG_H-1 → FLUSH.
  - FLUSH: pix_ready=0. Produces IMG_W+1 outputs, one per cycle, with no input. After the last one → IDLE, busy=0.
- Output timing:
  - Output for centre index k has valid=1 one cycle after the accept of input index k+IMG_W+1 (or the matching FLUSH cycle).
  - Input stalls (pix_valid=0) stall output generation; valid stays 0 during stalls.
  - Exactly IMG_W*IMG_H outputs per frame.
  - frame_done=1 together with output index IMG_W*IMG_H-1.
- Border rule: centre with x=0, x=IMG_W-1, y=0 or y=IMG_H-1 → edge_out=0, valid=1.
- Kernels (P[x][y]):
  - Gx = P[x-1][y-1] + 2P[x-1][y] + P[x-1][y+1] - P[x+1][y-1] - 2P[x+1][y] - P[x+1][y+1]
  - Gy = P[x-1][y-1] + 2P[x][y-1] + P[x+1][y-1] - P[x-1][y+1] - 2P[x][y+1] - P[x+1][y+1]
- Arithmetic:
  - Gx and Gy are signed, PIX_W+4 bits, with no overflow.
  - MAG_MODE=0: m = (Gx+Gy)/2, truncated toward zero.
  - MAG_MODE=1: m = |Gx|+|Gy|.
  - edge_out = 0 if m<0; 2^PIX_W-1 if m>2^PIX_W-1; otherwise m.
- Line buffers wrap per row. Window columns shift on every accept or flush step. Row wrap must not mix pixels from different rows into a window; window edges are masked by the border rule.
- pix_valid while pix_ready=0 is ignored; no pixel is consumed.
- valid=0 whenever no output is produced; edge_out holds its last value.

Optional Feature:
- Macro SOBEL_THRESH_EN.
- Defined: after clamping, edge_out = (m >= THRESH) ? 2^PIX_W-1 : 0. Border pixels stay 0.
- Undefined: edge_out is the clamped magnitude and the THRESH parameter is unused.
- Timing and handshake are identical in both builds.

Test Plan:
- Flat frame (IMG_W=IMG_H=8, PIX_W=8), all pixels 100, pix_valid held high → 64 outputs, all 0; frame_done on output 63; busy falls after it.
- Step with columns 0-3=255 and 4-7=0, MAG_MODE=0 → interior outputs at x=3,4 = 255 (Gx=1020 clamps); other interior = 0; borders = 0.
- Step with columns 0-3=0 and 4-7=255: MAG_MODE=0 → all 0 (negative clamps); MAG_MODE=1 → x=3,4 = 255.
- Random pix_valid gaps (~50% duty) → output stream identical to the gap-free run; no valid during stalls; pix_ready=0 during the 9 FLUSH cycles.
- rst pulled low at pixel 30, then released → outputs all 0 and busy=0 immediately; the next frame from (0,0) matches the golden model.
- SOBEL_THRESH_EN with THRESH=128 on a ramp image of 20 per column → outputs are only 0 or 255; 255 exactly where the golden magnitude is >=128.
